// File: rtl/pe_seq_ctrl_if.sv
// PE mode type and the sequencer control/memory bus.
// PE_SEQ_CTRL_PERF_EN adds the cycle and stall counter outputs.
package pe_seq_ctrl_pkg;
   typedef enum logic [3:0] {
      PE_MODE_NTT    = 4'h0,
      PE_MODE_INTT   = 4'h1,
      PE_MODE_PWM    = 4'h2,
      PE_MODE_ADD    = 4'h3,
      PE_MODE_SUB    = 4'h4,
      PE_MODE_COMP   = 4'h8,
      PE_MODE_DECOMP = 4'h9
   } pe_mode_e;
endpackage

interface pe_seq_ctrl_if #(
   parameter int AW = 7
);
   import pe_seq_ctrl_pkg::*;

   logic          start_i;
   pe_mode_e      mode_i;
   logic          hold_i;
   logic          abort_i;
   logic          rd_en_o;
   logic [AW-1:0] rd_addr_o;
   pe_mode_e      pe_ctrl_o;
   logic          pe_valid_o;
   logic          wr_en_o;
   logic [AW-1:0] wr_addr_o;
   logic          busy_o;
   logic          done_o;
`ifdef PE_SEQ_CTRL_PERF_EN
   logic [15:0]   cycle_cnt_o;
   logic [15:0]   stall_cnt_o;

   modport master (
      output start_i, mode_i, hold_i, abort_i,
      input  rd_en_o, rd_addr_o, pe_ctrl_o, pe_valid_o,
      input  wr_en_o, wr_addr_o, busy_o, done_o,
      input  cycle_cnt_o, stall_cnt_o
   );
   modport slave (
      input  start_i, mode_i, hold_i, abort_i,
      output rd_en_o, rd_addr_o, pe_ctrl_o, pe_valid_o,
      output wr_en_o, wr_addr_o, busy_o, done_o,
      output cycle_cnt_o, stall_cnt_o
   );
`else
   modport master (
      output start_i, mode_i, hold_i, abort_i,
      input  rd_en_o, rd_addr_o, pe_ctrl_o, pe_valid_o,
      input  wr_en_o, wr_addr_o, busy_o, done_o
   );
   modport slave (
      input  start_i, mode_i, hold_i, abort_i,
      output rd_en_o, rd_addr_o, pe_ctrl_o, pe_valid_o,
      output wr_en_o, wr_addr_o, busy_o, done_o
   );
`endif
endinterface

// File: rtl/pe_seq_ctrl.sv
// PE lane sequencer: issues operand reads, aligns write-back to PE latency.
// Optional PE_SEQ_CTRL_PERF_EN adds saturating busy/stall cycle counters.
module pe_seq_ctrl
   import pe_seq_ctrl_pkg::*;
#(
   parameter int ADDR_N = 128,
   parameter int AW     = $clog2(ADDR_N)
) (
   input logic        clk,
   input logic        rst,
   pe_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_e;

   localparam logic [AW:0] LAST = (AW+1)'(ADDR_N - 1);

   state_e            state;
   state_e            state_n;
   logic [AW:0]       issue_cnt;
   logic [AW:0]       wr_cnt;
   pe_mode_e          mode_q;
   logic              lat3;
   logic [4:0]        sr_v;
   logic [4:0][AW-1:0] sr_a;
   logic              tap_v;
   logic [AW-1:0]     tap_a;
   logic              rd_en;
   logic              wr_en;
   logic              accept;
   logic              flush;

   // Write-back tap: one memory cycle plus LAT PE stages.
   always_comb begin
      tap_v = lat3 ? sr_v[3] : sr_v[4];
      tap_a = lat3 ? sr_a[3] : sr_a[4];
   end

   // Next state, issue and write-back strobes; abort beats last issue/write.
   always_comb begin
      state_n = state;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      accept  = 1'b0;
      flush   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start_i) begin
               accept  = 1'b1;
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.abort_i) begin
               flush   = 1'b1;
               state_n = S_IDLE;
            end else begin
               rd_en = !bus.hold_i;
               wr_en = tap_v;
               if (rd_en && issue_cnt == LAST)
                  state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (bus.abort_i) begin
               flush   = 1'b1;
               state_n = S_IDLE;
            end else begin
               wr_en = tap_v;
               if (wr_en && wr_cnt == LAST)
                  state_n = S_DONE;
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   // Mode/latency latch and issue/write counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_cnt <= '0;
         wr_cnt    <= '0;
         mode_q    <= PE_MODE_NTT;
         lat3      <= 1'b0;
      end else if (accept) begin
         issue_cnt <= '0;
         wr_cnt    <= '0;
         mode_q    <= bus.mode_i;
         lat3      <= bus.mode_i[3];
      end else begin
         if (rd_en) issue_cnt <= issue_cnt + (AW+1)'(1);
         if (wr_en) wr_cnt    <= wr_cnt + (AW+1)'(1);
      end
   end

   // In-flight tracker; abort discards every pending entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_v <= '0;
         sr_a <= '0;
      end else if (flush) begin
         sr_v <= '0;
         sr_a <= '0;
      end else begin
         sr_v <= {sr_v[3:0], rd_en};
         sr_a <= {sr_a[3:0], issue_cnt[AW-1:0]};
      end
   end

   assign bus.rd_en_o    = rd_en;
   assign bus.rd_addr_o  = rd_en ? issue_cnt[AW-1:0] : '0;
   assign bus.pe_ctrl_o  = mode_q;
   assign bus.pe_valid_o = sr_v[0];
   assign bus.wr_en_o    = wr_en;
   assign bus.wr_addr_o  = wr_en ? tap_a : '0;
   assign bus.busy_o     = (state != S_IDLE);
   assign bus.done_o     = (state == S_DONE);

`ifdef PE_SEQ_CTRL_PERF_EN
   logic [15:0] cyc_q;
   logic [15:0] stall_q;

   // Saturating busy-cycle and issue-stall counters, cleared on start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q   <= '0;
         stall_q <= '0;
      end else if (accept) begin
         cyc_q   <= '0;
         stall_q <= '0;
      end else begin
         if (state != S_IDLE && cyc_q != 16'hFFFF)
            cyc_q <= cyc_q + 16'd1;
         if (state == S_ISSUE && bus.hold_i && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
      end
   end

   assign bus.cycle_cnt_o = cyc_q;
   assign bus.stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: timestamp-based reference model and scoreboard.
// Directed scenarios from the plan plus randomized hold/abort/start runs.
module tb_pe_seq_ctrl;
   import pe_seq_ctrl_pkg::*;

   localparam int N = 128;

   typedef struct {
      bit       busy;
      bit       done;
      bit       rd;
      bit       pev;
      int       addr;
      pe_mode_e mode;
      int       cc;
      int       sc;
   } st_t;

   typedef struct {
      int cyc;
      int addr;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pe_seq_ctrl_if #(.AW(7)) bus();

   pe_seq_ctrl #(.ADDR_N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int t_run  = 0;
   int t_fail = 0;
   int cyc    = 0;

   st_t st_q[$];
   wr_t wr_q[$];

   bit       m_busy = 0;
   bit       m_prev = 0;
   int       m_iss  = 0;
   int       m_lat  = 4;
   int       m_done = -1;
   pe_mode_e m_mode = PE_MODE_NTT;
   int       m_cc   = 0;
   int       m_sc   = 0;

   pe_mode_e modes[7] = '{PE_MODE_NTT, PE_MODE_INTT, PE_MODE_PWM,
                          PE_MODE_ADD, PE_MODE_SUB, PE_MODE_COMP,
                          PE_MODE_DECOMP};

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      t_run++;
      if (act !== exp) begin
         t_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, act, exp);
      end
   endtask

   task automatic mreset();
      m_busy = 0;
      m_prev = 0;
      m_iss  = 0;
      m_done = -1;
      m_mode = PE_MODE_NTT;
      m_cc   = 0;
      m_sc   = 0;
      wr_q.delete();
   endtask

   // One clock of stimulus; the model predicts this cycle's outputs
   // from whole-run bookkeeping (issue count, due times of results).
   task automatic step(input bit s, input bit h, input bit a,
                       input pe_mode_e m, input bit r);
      st_t e;
      @(posedge clk);
      #1;
      cyc++;
      bus.start_i = s;
      bus.hold_i  = h;
      bus.abort_i = a;
      bus.mode_i  = m;
      rst         = r;
      if (!r) begin
         mreset();
         #1;
         chk("rst_rd_en", bus.rd_en_o, 0);
         chk("rst_wr_en", bus.wr_en_o, 0);
         chk("rst_busy", bus.busy_o, 0);
         chk("rst_done", bus.done_o, 0);
         chk("rst_pe_valid", bus.pe_valid_o, 0);
         chk("rst_pe_ctrl", bus.pe_ctrl_o, PE_MODE_NTT);
      end
      e.busy = m_busy;
      e.done = 0;
      e.rd   = 0;
      e.pev  = m_prev;
      e.addr = 0;
      e.mode = m_mode;
      e.cc   = m_cc;
      e.sc   = m_sc;
      if (r) begin
         if (!m_busy) begin
            if (s) begin
               m_busy = 1;
               m_mode = m;
               m_lat  = m[3] ? 3 : 4;
               m_iss  = 0;
               m_done = -1;
               m_cc   = 0;
               m_sc   = 0;
            end
         end else begin
            if (m_cc < 16'hFFFF) m_cc++;
            if (m_iss < N && h && cyc != m_done && m_sc < 16'hFFFF) m_sc++;
            if (cyc == m_done) begin
               e.done = 1;
               m_busy = 0;
            end else if (a) begin
               while (wr_q.size() > 0 && wr_q[wr_q.size()-1].cyc >= cyc)
                  void'(wr_q.pop_back());
               m_busy = 0;
            end else if (m_iss < N && !h) begin
               e.rd   = 1;
               e.addr = m_iss;
               wr_q.push_back('{cyc + 1 + m_lat, m_iss});
               m_iss++;
               if (m_iss == N) m_done = cyc + 2 + m_lat;
            end
         end
      end
      m_prev = e.rd;
      st_q.push_back(e);
   endtask

   // Monitor: pops the per-cycle expectation and the timed write queue.
   always @(negedge clk) begin
      st_t e;
      if (st_q.size() > 0) begin
         e = st_q.pop_front();
         chk("busy", bus.busy_o, e.busy);
         chk("done", bus.done_o, e.done);
         chk("rd_en", bus.rd_en_o, e.rd);
         if (e.rd) chk("rd_addr", bus.rd_addr_o, e.addr);
         chk("pe_valid", bus.pe_valid_o, e.pev);
         chk("pe_ctrl", bus.pe_ctrl_o, e.mode);
`ifdef PE_SEQ_CTRL_PERF_EN
         chk("cycle_cnt", bus.cycle_cnt_o, e.cc);
         chk("stall_cnt", bus.stall_cnt_o, e.sc);
`endif
         if (bus.wr_en_o) begin
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
               chk("wr_addr", bus.wr_addr_o, wr_q[0].addr);
               void'(wr_q.pop_front());
            end else begin
               chk("wr_en_extra", bus.wr_en_o, 0);
            end
         end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
            chk("wr_en_missing", bus.wr_en_o, 1);
            void'(wr_q.pop_front());
         end
      end
   end

   // One scenario; k counts cycles from the start pulse at k=0.
   task automatic run(input pe_mode_e m, input int len, input int hold_pct,
                      input int hlo, input int hhi, input int ab,
                      input int st2, input int rk);
      bit s, h, a, r;
      pe_mode_e mm;
      for (int k = 0; k < len; k++) begin
         mm = m;
         s  = (k == 0) || (k == st2);
         if (k == st2) mm = (m == PE_MODE_COMP) ? PE_MODE_NTT : PE_MODE_COMP;
         if (hold_pct > 0 && k > 0 && k < 120 && $urandom_range(0, 39) == 0) begin
            s  = 1;
            mm = modes[$urandom_range(0, 6)];
         end
         h = (k >= hlo && k <= hhi);
         if (hold_pct > 0) h = ($urandom_range(0, 99) < hold_pct);
         a = (k == ab);
         r = !(rk >= 0 && k >= rk && k < rk + 2);
         step(s, h, a, (k == 0) ? m : mm, r);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, PE_MODE_NTT, 1);
   endtask

   initial begin
      bus.start_i = 0;
      bus.hold_i  = 0;
      bus.abort_i = 0;
      bus.mode_i  = PE_MODE_NTT;
      step(0, 0, 0, PE_MODE_NTT, 0);
      step(0, 0, 0, PE_MODE_NTT, 0);
      idle(3);
      run(PE_MODE_NTT,  140, 0, -1, -1, -1, -1, -1);
      idle(4);
      run(PE_MODE_COMP, 140, 0, -1, -1, -1, -1, -1);
      idle(4);
      run(PE_MODE_INTT, 145, 0, 10, 14, -1, -1, -1);
      idle(4);
      run(PE_MODE_NTT,   52, 0, -1, -1, 50, -1, -1);
      run(PE_MODE_DECOMP, 140, 0, -1, -1, -1, -1, -1);
      idle(4);
      run(PE_MODE_PWM,  140, 0, -1, -1, -1, 20, -1);
      idle(4);
      run(PE_MODE_NTT,   80, 0, -1, -1, -1, -1, 70);
      idle(4);
      run(PE_MODE_COMP, 140, 0, -1, -1, 133, -1, -1);
      idle(4);
      for (int i = 0; i < 6; i++) begin
         int ab;
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 180)) : -1;
         run(modes[$urandom_range(0, 6)], 200, 20, -1, -1, ab, -1, -1);
         idle(3);
      end
      idle(200);
      @(negedge clk);
      #1;
      chk("wr_q_empty", wr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", t_run, t_fail);
      $finish;
   end
endmodule

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
Sequencer for one processing element (PE) lane of the polynomial arithmetic unit. On a start pulse it streams ADDR_N coefficient-pair addresses into the PE, drives the PE mode and valid inputs, and tracks in-flight operations. It generates write-back addresses and enables aligned to the PE's mode-dependent latency, then reports completion. It sits between the AU top-level controller and the coefficient memories/PE datapath.

Parameters:
ADDR_N, 128, coefficient pairs processed per operation (power of two, ≥4)
AW, 7, address width; $clog2(ADDR_N)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start_i  in  1  one-cycle start request; accepted only in IDLE
mode_i  in  pe_mode_e  operation mode; sampled on accepted start
hold_i  in  1  memory-port stall; blocks issue, never blocks write-back
abort_i  in  1  synchronous abort request
rd_en_o  out  1  operand read enable
rd_addr_o  out  AW  operand read address
pe_ctrl_o  out  pe_mode_e  mode to PE, held constant for the whole run
pe_valid_o  out  1  operand valid to PE; equals rd_en_o delayed 1 cycle (memory read latency 1)
wr_en_o  out  1  result write enable
wr_addr_o  out  AW  result write address
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse when the last result is written

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0. pe_ctrl_o=PE_MODE_NTT. Counters and the in-flight shift register are cleared.
- Latency LAT: 3 if mode bit 3 = 1 (compress/decompress), otherwise 4. LAT is latched with the mode at start.
- Total read-to-write latency = 1 (memory) + LAT.
- States:
  - IDLE: start_i=1 → ISSUE. Latch the mode and clear issue_cnt and wr_cnt.
  - ISSUE: rd_en_o = !hold_i. When rd_en_o=1, rd_addr_o = issue_cnt and issue_cnt increments. When the last address (ADDR_N-1) issues → DRAIN.
  - DRAIN: no reads. When wr_cnt reaches ADDR_N → DONE.
  - DONE: done_o=1 for exactly one cycle → IDLE.
- Tracking: a 5-deep shift register of {valid, addr} is fed from {rd_en_o, rd_addr_o}. wr_en_o/wr_addr_o come from tap 1+LAT. Each wr_en_o increments wr_cnt.
- hold_i:
  - Bubbles only the issue stage. Already-issued entries still drain on schedule.
  - hold_i is ignored in DRAIN, DONE and IDLE.
- start_i while busy_o=1: ignored, no queueing.
- pe_ctrl_o changes only on an accepted start. It holds its value after DONE until the next start.
- Write addresses come out in increasing order 0..ADDR_N-1, one per issued read, with gaps matching hold bubbles.
- abort_i in ISSUE or DRAIN:
  - Issue stops immediately (rd_en_o=0 that cycle).
  - The shift register is flushed the same cycle, so no further wr_en_o.
  - Next state is IDLE with no done_o.
- abort_i in IDLE or DONE: ignored.
- abort_i takes precedence over a same-cycle last issue or last write.
- Async reset mid-run: immediate return to the reset values. In-flight PE results are discarded by construction, since wr_en_o=0.
- issue_cnt and wr_cnt are AW+1 bits wide so ADDR_N is representable. rd_addr_o/wr_addr_o are the low AW bits.

Optional Feature:
PE_SEQ_CTRL_PERF_EN
- Defined: adds output port cycle_cnt_o [15:0] and stall_cnt_o [15:0].
  - Both clear on accepted start.
  - cycle_cnt_o counts every busy cycle, including the DONE cycle.
  - stall_cnt_o counts ISSUE cycles with hold_i=1.
  - Both saturate at 16'hFFFF and hold their values in IDLE. Reset value is 0.
- Undefined: the ports and counters do not exist. Functionality is otherwise identical.

Test Plan:
- NTT, ADDR_N=128, hold_i=0:
  - start at cycle 0; reads at cycles 1..128, addr 0..127.
  - wr_en_o at cycles 6..133, addr 0..127.
  - done_o at cycle 134, busy_o low at 135.
- Compress mode (bit3=1), same stimulus: writes at cycles 5..132 and done_o at cycle 133, confirming LAT=3.
- hold_i=1 for cycles 10–14 during NTT:
  - Reads skip those cycles and addr 9 issues at cycle 15.
  - Writes keep the same 5-cycle gap pattern shifted by 5.
  - stall_cnt_o=5 with PE_SEQ_CTRL_PERF_EN.
- abort_i at cycle 50:
  - No rd_en_o from cycle 50 and no wr_en_o from cycle 50.
  - No done_o; busy_o=0 at cycle 51.
  - A new start at cycle 52 runs a clean full operation.
- start_i pulsed at cycle 20 mid-run: ignored; mode and pe_ctrl_o unchanged; exactly 128 writes.
- rst asserted at cycle 70 then released: all outputs 0 asynchronously; IDLE after release; no stray wr_en_o.
